multicycle_controller: RTL

Parametrised multi-cycle control unit for the single-bus datapath. It replaces per-opcode combinational decode with an FSM that sequences fetch, decode, execute, memory and write-back over several cycles, sharing one memory port for instructions and data. It adds a ready/valid memory handshake with a wait-state timeout, sticky illegal-opcode and fault reporting, and a per-instruction retire pulse. It sits between the instruction register (which supplies `opcode`) and the datapath muxes and enables.

---
 rtl/mc_pkg.sv | 50 +++++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multicycle_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller.
// Opcodes, ALU ops, datapath mux selects and the FSM state type.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SLTI = 6'b000010;
    localparam logic [5:0] OP_LW   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b000100;
    localparam logic [5:0] OP_BEQ  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000110;
    localparam logic [5:0] OP_JR   = 6'b000111;
    localparam logic [5:0] OP_JAL  = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b011;
    localparam logic [2:0] ALU_RTYPE = 3'b101;

    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_4      = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REGA   = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU,
        S_EXEC_I, S_WB_I, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP,
        S_JAL, S_JR, S_HALT, S_FAULT
    } state_e;

    // States that wait on the shared memory port
    function automatic logic is_wait_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Consecutive wait-cycle counter for the memory handshake.
// Ports: clk, rst_n, i_clear (zero the count), o_expired (limit hit this cycle).
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_expired
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned LIM   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // r_cnt holds the waits already seen, so the current wait is the
    // MEM_TIMEOUT-th one when r_cnt reaches MEM_TIMEOUT-1.
    assign o_expired = (MEM_TIMEOUT != 0) && !i_clear && (r_cnt == CNT_W'(LIM));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FSM control unit for the single-bus datapath.
// Ports: clk, rst_n, opcode, mem_ready in; datapath enables/selects, retire, illegal, fault out.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned OPC_W       = 6,
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wd_sel,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               retire,
    output logic               illegal,
    output logic               fault
);

    state_e     r_state;
    state_e     w_next;
    logic       r_illegal;
    logic       r_fault;
    logic       w_done;
    logic       w_clear;
    logic       w_expired;
    logic [2:0] w_alu_op;

    // Handshake completion is masked while reset is held so no
    // enable can fire from a stray mem_ready during reset.
    assign w_done  = mem_ready & rst_n;
    assign w_clear = !is_wait_state(r_state) || w_done;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_HALT);
            r_fault   <= r_fault | (w_next == S_FAULT);
        end
    end

    assign illegal = r_illegal;
    assign fault   = r_fault;
    assign alu_op  = ALUOP_W'(w_alu_op);

    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = RD_RT;
        wd_sel        = WD_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        w_alu_op      = ALU_ADD;
        pc_src        = PCS_ALU;
        retire        = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                if (w_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OPC_W'(OP_R):    w_next = S_EXEC_R;
                    OPC_W'(OP_ADDI),
                    OPC_W'(OP_SLTI): w_next = S_EXEC_I;
                    OPC_W'(OP_LW),
                    OPC_W'(OP_SW):   w_next = S_MEM_ADDR;
                    OPC_W'(OP_BEQ):  w_next = S_BRANCH;
                    OPC_W'(OP_J):    w_next = S_JUMP;
                    OPC_W'(OP_JR):   w_next = S_JR;
                    OPC_W'(OP_JAL):  w_next = S_JAL;
                    default:         w_next = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALU_RTYPE;
                w_next    = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = RD_RD;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_alu_op  = (opcode == OPC_W'(OP_SLTI)) ? ALU_SLT : ALU_ADD;
                w_next    = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = (opcode == OPC_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (w_done) begin
                    w_next = S_MEM_WB;
                end else if (w_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                wd_sel    = WD_MDR;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (w_done) begin
                    retire = 1'b1;
                    w_next = S_FETCH;
                end else if (w_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                w_alu_op      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCS_ALUOUT;
                retire        = 1'b1;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCS_JUMP;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4, which becomes the link value
                pc_write  = 1'b1;
                pc_src    = PCS_JUMP;
                reg_write = 1'b1;
                reg_dst   = RD_R31;
                wd_sel    = WD_PC;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = PCS_REGA;
                retire   = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            S_FAULT: w_next = S_FAULT;
        endcase
    end

endmodule
